bfly_kernel: RTL and testbench



---
 rtl/bfly_pkg.sv | 19 +
 rtl/bfly_kernel_if.sv | 30 +++
 rtl/bfly_lane.sv | 108 ++++++++++
 rtl/bfly_kernel.sv | 83 ++++++++
 tb/tb_bfly_kernel.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bfly_pkg.sv
// Shared constants for the butterfly kernel: mode codes, the default
// modulus and the lane-slice helper used to pack and unpack beats.
package bfly_pkg;

  localparam logic [7:0] BFLY_BYPASS = 8'h00;
  localparam logic [7:0] BFLY_CT     = 8'h01;
  localparam logic [7:0] BFLY_GS     = 8'h02;

  // 2^64 - 2^32 + 1, the usual 64-bit NTT-friendly prime.
  localparam logic [63:0] BFLY_DEFAULT_Q = 64'hFFFF_FFFF_0000_0001;

  // LSB of coefficient idx (0 = a, 1 = b) of a lane within a packed beat.
  function automatic int unsigned lane_lsb(input int unsigned lane,
                                           input int unsigned idx,
                                           input int unsigned width);
    return (2 * lane + idx) * width;
  endfunction

endpackage

// File: rtl/bfly_kernel_if.sv
// Load/store stream bundle of the butterfly kernel. The kernel takes the
// slave view; the load/store DMA side (or a bench) takes the master view.
interface bfly_kernel_if #(
  parameter int COEF_WIDTH = 64,
  parameter int LANES      = 2
);
  localparam int DATA_WIDTH = 2 * COEF_WIDTH * LANES;

  logic                        ld_vld;
  logic                        ld_rdy;
  logic [DATA_WIDTH-1:0]       ld_dat;
  logic [COEF_WIDTH*LANES-1:0] tw_dat;
  logic                        sw_vld;
  logic                        sw_rdy;
  logic [DATA_WIDTH-1:0]       sw_dat;
  logic                        sw_lst;
  logic [7:0]                  mode;
  logic                        decode;

  modport slave (
    input  ld_vld, ld_dat, tw_dat, sw_rdy, mode, decode,
    output ld_rdy, sw_vld, sw_dat, sw_lst
  );

  modport master (
    output ld_vld, ld_dat, tw_dat, sw_rdy, mode, decode,
    input  ld_rdy, sw_vld, sw_dat, sw_lst
  );

endinterface

// File: rtl/bfly_lane.sv
// One butterfly lane: S1 operand register, S2 product/difference,
// S3 modular add/sub into the output register. All stages advance on en;
// stage occupancy is tracked by the caller.
module bfly_lane
  import bfly_pkg::*;
#(
  parameter int           W = 64,
  parameter logic [W-1:0] Q = W'(BFLY_DEFAULT_Q)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] w,
  input  logic [7:0]   mode,
  output logic [W-1:0] ao,
  output logic [W-1:0] bo
);

  // Operands x, y must already be reduced (< Q).
  function automatic logic [W-1:0] add_mod(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= {1'b0, Q}) s = s - {1'b0, Q};
    return s[W-1:0];
  endfunction

  function automatic logic [W-1:0] sub_mod(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0] d;
    if (x >= y) d = {1'b0, x} - {1'b0, y};
    else        d = {1'b0, x} + {1'b0, Q} - {1'b0, y};
    return d[W-1:0];
  endfunction

  // Full double-width product, so raw (unreduced) operands are fine here.
  function automatic logic [W-1:0] mul_mod(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    p = p % {{W{1'b0}}, Q};
    return p[W-1:0];
  endfunction

  logic [W-1:0] a1, b1, w1;
  logic [7:0]   m1;
  logic [W-1:0] x2, y2;
  logic [7:0]   m2;
  logic [W-1:0] a_red, b_red, x2_d, y2_d, ao_d, bo_d;

  // S2: reduce inputs, form the twiddle product (CT) or sum and
  // twiddled difference (GS); bypass leaves the raw operands untouched.
  always_comb begin
    // NOTE: every always_comb output is assigned a default first so no path leaves it unassigned (no latch).
    a_red = a1 % Q;
    b_red = b1 % Q;
    x2_d  = a1;
    y2_d  = b1;
    case (m1)
      BFLY_CT: begin
        x2_d = a_red;
        y2_d = mul_mod(w1, b1);
      end
      BFLY_GS: begin
        x2_d = add_mod(a_red, b_red);
        y2_d = mul_mod(sub_mod(a_red, b_red), w1);
      end
      default: ;
    endcase
  end

  // S3: CT finishes with the modular add/sub; GS and bypass pass through.
  always_comb begin
    ao_d = x2;
    bo_d = y2;
    if (m2 == BFLY_CT) begin
      ao_d = add_mod(x2, y2);
      bo_d = sub_mod(x2, y2);
    end
  end

  // Pipeline registers, all held together while en is low.
  always_ff @(posedge clk) begin
    // NOTE: datapath registers are reset too, so sw_dat reads zero after reset rather than stale data.
    if (rst) begin
      a1 <= '0;
      b1 <= '0;
      w1 <= '0;
      m1 <= BFLY_BYPASS;
      x2 <= '0;
      y2 <= '0;
      m2 <= BFLY_BYPASS;
      ao <= '0;
      bo <= '0;
    end else if (en) begin
      // NOTE: non-blocking assignments let every stage sample the previous stage's old value on the same edge.
      a1 <= a;
      b1 <= b;
      w1 <= w;
      m1 <= mode;
      x2 <= x2_d;
      y2 <= y2_d;
      m2 <= m1;
      ao <= ao_d;
      bo <= bo_d;
    end
  end

endmodule

// File: rtl/bfly_kernel.sv
// Multi-lane modular butterfly kernel between the load and store DMA.
// Holds the stage valid bits, mode register, block counter and the
// valid/ready handshake; the arithmetic lives in bfly_lane.
module bfly_kernel
  import bfly_pkg::*;
#(
  parameter int                     pCOEF_WIDTH = 64,
  parameter int                     pLANES      = 2,
  parameter logic [pCOEF_WIDTH-1:0] pQ          = pCOEF_WIDTH'(BFLY_DEFAULT_Q),
  parameter int                     pBLOCK_LEN  = 256
) (
  input  logic          clk,
  input  logic          rst,
  bfly_kernel_if.slave  bus
);

  localparam int pDATA_WIDTH = 2 * pCOEF_WIDTH * pLANES;
  localparam int CNT_W       = (pBLOCK_LEN > 1) ? $clog2(pBLOCK_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(pBLOCK_LEN - 1);

  logic                   s1_vld, s2_vld, s3_vld;
  logic [7:0]             mode_q;
  logic [CNT_W-1:0]       cnt;
  logic                   en;
  logic                   ld_hs, sw_hs, empty;
  logic [pDATA_WIDTH-1:0] sw_dat_w;

  // The whole pipeline moves as one; it only freezes when the output is
  // occupied and the store side is not taking it.
  assign en    = !s3_vld || bus.sw_rdy;
  assign ld_hs = bus.ld_vld && en;
  assign sw_hs = s3_vld && bus.sw_rdy;
  assign empty = !s1_vld && !s2_vld && !s3_vld;

  assign bus.ld_rdy = en;
  assign bus.sw_vld = s3_vld;
  assign bus.sw_dat = sw_dat_w;
  assign bus.sw_lst = s3_vld && (cnt == CNT_LAST);

  // Valid bits, mode register and block counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld <= 1'b0;
      s2_vld <= 1'b0;
      s3_vld <= 1'b0;
      mode_q <= BFLY_BYPASS;
      cnt    <= '0;
    end else begin
      if (en) begin
        s1_vld <= ld_hs;
        s2_vld <= s1_vld;
        s3_vld <= s2_vld;
      end
      // A beat latches mode_q in its acceptance cycle, so a decode in the
      // same cycle only reaches later beats.
      if (bus.decode) mode_q <= bus.mode;
      // Restarting the block count is only safe with nothing in flight.
      if (bus.decode && empty) begin
        cnt <= '0;
      end else if (sw_hs) begin
        cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
      end
    end
  end

  for (genvar i = 0; i < pLANES; i++) begin : g_lane
    bfly_lane #(
      .W (pCOEF_WIDTH),
      .Q (pQ)
    ) u_lane (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .a    (bus.ld_dat[lane_lsb(i, 0, pCOEF_WIDTH) +: pCOEF_WIDTH]),
      .b    (bus.ld_dat[lane_lsb(i, 1, pCOEF_WIDTH) +: pCOEF_WIDTH]),
      .w    (bus.tw_dat[i*pCOEF_WIDTH +: pCOEF_WIDTH]),
      .mode (mode_q),
      .ao   (sw_dat_w[lane_lsb(i, 0, pCOEF_WIDTH) +: pCOEF_WIDTH]),
      .bo   (sw_dat_w[lane_lsb(i, 1, pCOEF_WIDTH) +: pCOEF_WIDTH])
    );
  end

endmodule

// File: tb/tb_bfly_kernel.sv
// Scoreboard bench for bfly_kernel with W=8, Q=17, two lanes, 4-beat blocks.
// Stimulus pushes hand-computed expected beats; a monitor pops and compares
// on every store handshake and checks stability while stalled.
module tb_bfly_kernel;
  import bfly_pkg::*;

  localparam int         W     = 8;
  localparam int         LANES = 2;
  localparam int         BLK   = 4;
  localparam logic [7:0] Q     = 8'd17;

  typedef struct packed {
    logic [31:0] dat;
    logic        lst;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bfly_kernel_if #(.COEF_WIDTH(W), .LANES(LANES)) bus ();

  bfly_kernel #(
    .pCOEF_WIDTH (W),
    .pLANES      (LANES),
    .pQ          (Q),
    .pBLOCK_LEN  (BLK)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   out_idx  = 0;
  bit   rdy_toggle = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pk(input logic [7:0] a0, input logic [7:0] b0,
                                     input logic [7:0] a1, input logic [7:0] b1);
    return {b1, a1, b0, a0};
  endfunction

  // Store-side ready: held high, or cycling 1,0,0,1 for the backpressure run.
  initial begin
    bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int k = 0;
    bus.sw_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_toggle) begin
        bus.sw_rdy = pat[k % 4];
        k++;
      end else begin
        bus.sw_rdy = 1'b1;
      end
    end
  end

  // Monitor: compare each store handshake with the scoreboard head.
  initial begin
    bit          prev_stall = 1'b0;
    logic [31:0] prev_dat   = '0;
    logic        prev_lst   = 1'b0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_dat_stable", bus.sw_dat, prev_dat);
          check("stall_lst_stable", bus.sw_lst, prev_lst);
        end
        if (bus.sw_vld) begin
          if (q.size() == 0) begin
            check("spurious_sw_vld", bus.sw_vld, 1'b0);
          end else if (bus.sw_rdy) begin
            e = q.pop_front();
            check("sw_dat", bus.sw_dat, e.dat);
            check("sw_lst", bus.sw_lst, e.lst);
          end
        end
        prev_stall = bus.sw_vld && !bus.sw_rdy;
        prev_dat   = bus.sw_dat;
        prev_lst   = bus.sw_lst;
      end
    end
  end

  // All stimulus tasks start and end just after a rising edge.
  task automatic decode_only(input logic [7:0] m);
    bus.decode = 1'b1;
    bus.mode   = m;
    @(posedge clk);
    #1;
    bus.decode = 1'b0;
    out_idx    = 0;
  endtask

  task automatic send(input logic [31:0] dat, input logic [15:0] tw,
                      input logic dec, input logic [7:0] m,
                      input bit push, input logic [31:0] exp_dat);
    int   tries = 0;
    exp_t e;
    bus.ld_vld = 1'b1;
    bus.ld_dat = dat;
    bus.tw_dat = tw;
    bus.decode = dec;
    bus.mode   = m;
    forever begin
      @(negedge clk);
      if (bus.ld_rdy) break;
      tries++;
      if (tries > 100) begin
        check("ld_rdy_timeout", bus.ld_rdy, 1'b1);
        break;
      end
      @(posedge clk);
      #1;
    end
    if (dec) out_idx = 0;
    if (push) begin
      e.dat = exp_dat;
      e.lst = ((out_idx % BLK) == BLK - 1);
      q.push_back(e);
      out_idx++;
    end
    @(posedge clk);
    #1;
    bus.ld_vld = 1'b0;
    bus.decode = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while (q.size() != 0 && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("drain_empty", q.size(), 0);
    q.delete();
    repeat (2) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int lat;
    rst        = 1'b1;
    bus.ld_vld = 1'b0;
    bus.ld_dat = '0;
    bus.tw_dat = '0;
    bus.mode   = 8'h00;
    bus.decode = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state, pipeline idle.
    @(negedge clk);
    check("rst_ld_rdy", bus.ld_rdy, 1'b1);
    check("rst_sw_vld", bus.sw_vld, 1'b0);
    check("rst_sw_lst", bus.sw_lst, 1'b0);
    check("rst_sw_dat", bus.sw_dat, 32'h0);
    @(posedge clk);
    #1;

    // CT: lane0 3,5,w2 -> 13,10; lane1 16,16,w16 -> wb=1: 0,15.
    decode_only(BFLY_CT);
    send(pk(8'd3, 8'd5, 8'd16, 8'd16), {8'd16, 8'd2}, 1'b0, 8'h00, 1'b1,
         pk(8'd13, 8'd10, 8'd0, 8'd15));
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.sw_vld && lat < 10);
    check("latency", lat, 3);
    @(posedge clk);
    #1;
    drain();

    // GS: lane0 3,5,w2 -> 8,13; lane1 20,30,w3 -> 50%17=16, (-10*3)%17=4.
    decode_only(BFLY_GS);
    send(pk(8'd3, 8'd5, 8'd20, 8'd30), {8'd3, 8'd2}, 1'b0, 8'h00, 1'b1,
         pk(8'd8, 8'd13, 8'd16, 8'd4));
    drain();
    // Decode to bypass alongside a beat: that beat still uses GS.
    send(pk(8'd3, 8'd5, 8'd20, 8'd30), {8'd3, 8'd2}, 1'b1, BFLY_BYPASS, 1'b1,
         pk(8'd8, 8'd13, 8'd16, 8'd4));
    send(pk(8'd3, 8'd5, 8'd20, 8'd30), {8'd3, 8'd2}, 1'b0, 8'h00, 1'b1,
         pk(8'd3, 8'd5, 8'd20, 8'd30));
    drain();

    // Nine bypass beats under 1,0,0,1 backpressure; last on beats 4 and 8.
    decode_only(BFLY_BYPASS);
    rdy_toggle = 1'b1;
    for (int i = 0; i < 9; i++) begin
      send(pk(8'(i), 8'(i + 16), 8'(i + 32), 8'(i + 48)), 16'h0, 1'b0, 8'h00, 1'b1,
           pk(8'(i), 8'(i + 16), 8'(i + 32), 8'(i + 48)));
    end
    drain();
    rdy_toggle = 1'b0;
    drain();

    // Unknown mode acts as bypass with unreduced values.
    decode_only(8'h7F);
    send(pk(8'd200, 8'd250, 8'd255, 8'd17), {8'd9, 8'd9}, 1'b0, 8'h00, 1'b1,
         pk(8'd200, 8'd250, 8'd255, 8'd17));
    drain();

    // Reset with two beats in flight: none may come out.
    decode_only(BFLY_CT);
    send(pk(8'd1, 8'd2, 8'd3, 8'd4), {8'd1, 8'd1}, 1'b0, 8'h00, 1'b0, 32'h0);
    send(pk(8'd1, 8'd2, 8'd3, 8'd4), {8'd1, 8'd1}, 1'b0, 8'h00, 1'b0, 32'h0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst     = 1'b0;
    out_idx = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_rst_sw_vld", bus.sw_vld, 1'b0);
      @(posedge clk);
      #1;
    end
    // Mode back at bypass and counter at 0: fourth beat is last of block.
    for (int i = 0; i < 4; i++) begin
      send(pk(8'd20, 8'd30, 8'(40 + i), 8'd50), {8'd5, 8'd7}, 1'b0, 8'h00, 1'b1,
           pk(8'd20, 8'd30, 8'(40 + i), 8'd50));
    end
    drain();

    check("scoreboard_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global time bound so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d checks so far", n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
